// File: rtl/vis_frame_reader.sv
// Receive side of the correlator visibility bus: captures whole frames into a
// two-bank ping-pong store and serves completed frames to a host read port.
module vis_frame_reader #(
    parameter int VIS_NUM = 12,
    parameter int ACCUM   = 32,
    localparam int ABITS  = $clog2(VIS_NUM)
) (
    input  logic               bus_clock,
    input  logic               bus_reset,
    input  logic [ACCUM-1:0]   bus_revis_i,
    input  logic [ACCUM-1:0]   bus_imvis_i,
    input  logic               bus_valid_i,
    output logic               bus_ready_o,
    input  logic               bus_last_i,
    output logic               frm_avail_o,
    output logic               frm_bank_o,
    input  logic               rd_en_i,
    input  logic [ABITS-1:0]   rd_addr_i,
    output logic               rd_valid_o,
    output logic [2*ACCUM-1:0] rd_data_o,
    input  logic               frm_done_i,
    output logic               frm_err_o,
    output logic [7:0]         err_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DROP  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    localparam logic [ABITS-1:0] LAST_IDX = ABITS'(VIS_NUM - 1);
    localparam logic [ABITS:0]   NUM_EXT  = (ABITS + 1)'(VIS_NUM);

    state_t               state_q, state_d;
    logic [ABITS-1:0]     cnt_q, cnt_d;
    logic                 wbank_q, wbank_d;
    logic                 rbank_q, rbank_d;
    logic [1:0]           full_q, full_d;
    logic                 ready_q, ready_d;
    logic                 avail_q, avail_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [2*ACCUM-1:0]   rd_data_q, rd_data_d;
    logic                 err_q, err_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 beat_s;
    logic                 release_s;
    logic                 wr_en_s;
    logic [2*ACCUM-1:0]   mem_q [2][VIS_NUM];

    assign beat_s    = bus_valid_i & ready_q;
    assign release_s = frm_done_i & avail_q;

    // Writer state register.
    always_ff @(posedge bus_clock or posedge bus_reset) begin
        if (bus_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Writer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!full_q[wbank_q]) state_d = S_FILL;
                else                  state_d = S_STALL;
            end
            S_FILL: begin
                if (beat_s && bus_last_i)             state_d = S_IDLE;
                else if (beat_s && cnt_q == LAST_IDX) state_d = S_DROP;
                else                                  state_d = S_FILL;
            end
            S_DROP: begin
                if (beat_s && bus_last_i) state_d = S_IDLE;
                else                      state_d = S_DROP;
            end
            S_STALL: begin
                if (!full_d[wbank_q]) state_d = S_FILL;
                else                  state_d = S_STALL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat counter, bank ownership and length-error bookkeeping.
    always_comb begin
        cnt_d       = cnt_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        full_d      = full_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        wr_en_s     = 1'b0;
        // Release and completion always target different banks, so both may apply.
        if (release_s) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end else begin
            rbank_d = rbank_q;
        end
        if (state_q == S_FILL && beat_s) begin
            wr_en_s = 1'b1;
            if (bus_last_i && cnt_q == LAST_IDX) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                cnt_d           = '0;
            end else if (bus_last_i || cnt_q == LAST_IDX) begin
                err_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ABITS'(1);
            end
        end else if (state_q == S_DROP && beat_s && bus_last_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
        if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        else                               err_count_d = err_count_q;
    end

    // Registered outputs: ready follows the next state, reads are one cycle deep.
    always_comb begin
        ready_d    = (state_d == S_FILL) || (state_d == S_DROP);
        avail_d    = full_d[rbank_d];
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (rd_en_i && avail_q) begin
            rd_valid_d = 1'b1;
            if ({1'b0, rd_addr_i} < NUM_EXT) rd_data_d = mem_q[rbank_q][rd_addr_i];
            else                             rd_data_d = '0;
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge bus_clock or posedge bus_reset) begin
        if (bus_reset) begin
            cnt_q       <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            ready_q     <= 1'b0;
            avail_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            ready_q     <= ready_d;
            avail_q     <= avail_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Frame storage; contents are only meaningful once a bank is marked full.
    always_ff @(posedge bus_clock) begin
        if (wr_en_s) mem_q[wbank_q][cnt_q] <= {bus_revis_i, bus_imvis_i};
    end

    assign bus_ready_o = ready_q;
    assign frm_avail_o = avail_q;
    assign frm_bank_o  = rbank_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign frm_err_o   = err_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_vis_frame_reader.sv
// Directed bench for vis_frame_reader: frame capture, ping-pong ordering,
// length errors, error saturation and mid-frame reset.
module tb_vis_frame_reader;

    localparam int VIS_NUM = 12;
    localparam int ACCUM   = 32;
    localparam int ABITS   = 4;

    logic             bus_clock;
    logic             bus_reset;
    logic [31:0]      bus_revis_i;
    logic [31:0]      bus_imvis_i;
    logic             bus_valid_i;
    logic             bus_ready_o;
    logic             bus_last_i;
    logic             frm_avail_o;
    logic             frm_bank_o;
    logic             rd_en_i;
    logic [ABITS-1:0] rd_addr_i;
    logic             rd_valid_o;
    logic [63:0]      rd_data_o;
    logic             frm_done_i;
    logic             frm_err_o;
    logic [7:0]       err_count_o;

    int n_checks = 0;
    int n_pass   = 0;

    vis_frame_reader #(.VIS_NUM(VIS_NUM), .ACCUM(ACCUM)) dut (
        .bus_clock   (bus_clock),
        .bus_reset   (bus_reset),
        .bus_revis_i (bus_revis_i),
        .bus_imvis_i (bus_imvis_i),
        .bus_valid_i (bus_valid_i),
        .bus_ready_o (bus_ready_o),
        .bus_last_i  (bus_last_i),
        .frm_avail_o (frm_avail_o),
        .frm_bank_o  (frm_bank_o),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .frm_done_i  (frm_done_i),
        .frm_err_o   (frm_err_o),
        .err_count_o (err_count_o)
    );

    initial bus_clock = 1'b0;
    always #5 bus_clock = ~bus_clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] vis_word(input logic [31:0] v);
        return {v, 32'd0 - v};
    endfunction

    task automatic tick();
        @(posedge bus_clock);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] v, input logic last);
        int wait_n;
        bus_valid_i = 1'b1;
        bus_revis_i = v;
        bus_imvis_i = 32'd0 - v;
        bus_last_i  = last;
        @(negedge bus_clock);
        wait_n = 0;
        while (!bus_ready_o && wait_n < 200) begin
            @(negedge bus_clock);
            wait_n++;
        end
        if (!bus_ready_o) check_eq("ready_timeout", {63'd0, bus_ready_o}, 64'd1);
        else tick();
        bus_valid_i = 1'b0;
        bus_last_i  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) send_beat(base + k, k == last_at);
    endtask

    task automatic rd_check(input string tag, input logic [ABITS-1:0] addr, input logic [63:0] exp);
        rd_en_i   = 1'b1;
        rd_addr_i = addr;
        tick();
        rd_en_i   = 1'b0;
        check_eq({tag, "_valid"}, {63'd0, rd_valid_o}, 64'd1);
        check_eq({tag, "_data"}, rd_data_o, exp);
    endtask

    task automatic release_bank();
        frm_done_i = 1'b1;
        tick();
        frm_done_i = 1'b0;
    endtask

    task automatic apply_reset();
        bus_reset = 1'b1;
        tick();
        tick();
        bus_reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {63'd0, bus_ready_o}, 64'd0);
        check_eq({tag, "_avail"}, {63'd0, frm_avail_o}, 64'd0);
        check_eq({tag, "_bank"}, {63'd0, frm_bank_o}, 64'd0);
        check_eq({tag, "_rdv"}, {63'd0, rd_valid_o}, 64'd0);
        check_eq({tag, "_rdd"}, rd_data_o, 64'd0);
        check_eq({tag, "_err"}, {63'd0, frm_err_o}, 64'd0);
        check_eq({tag, "_cnt"}, {56'd0, err_count_o}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_reset   = 1'b1;
        bus_revis_i = 32'd0;
        bus_imvis_i = 32'd0;
        bus_valid_i = 1'b0;
        bus_last_i  = 1'b0;
        rd_en_i     = 1'b0;
        rd_addr_i   = 4'd0;
        frm_done_i  = 1'b0;
        tick();
        check_reset_outputs("por");
        bus_reset = 1'b0;
        tick();
        check_eq("ready_after_reset", {63'd0, bus_ready_o}, 64'd1);

        // Single frame, re=k im=-k.
        send_frame(32'd0, 12, 11);
        check_eq("f1_avail", {63'd0, frm_avail_o}, 64'd1);
        check_eq("f1_bank", {63'd0, frm_bank_o}, 64'd0);
        check_eq("f1_ready_gap", {63'd0, bus_ready_o}, 64'd0);
        tick();
        check_eq("f1_ready_back", {63'd0, bus_ready_o}, 64'd1);
        rd_check("f1_a5", 4'd5, 64'h00000005_FFFFFFFB);
        rd_check("f1_a0", 4'd0, 64'h00000000_00000000);
        rd_check("f1_a11", 4'd11, 64'h0000000B_FFFFFFF5);
        rd_check("f1_oob", 4'd13, 64'd0);
        rd_check("f1_a11b", 4'd11, 64'h0000000B_FFFFFFF5);
        release_bank();
        check_eq("f1_done_avail", {63'd0, frm_avail_o}, 64'd0);
        check_eq("f1_done_bank", {63'd0, frm_bank_o}, 64'd1);
        rd_en_i   = 1'b1;
        rd_addr_i = 4'd2;
        tick();
        rd_en_i   = 1'b0;
        check_eq("noavail_rdv", {63'd0, rd_valid_o}, 64'd0);
        check_eq("noavail_hold", rd_data_o, 64'h0000000B_FFFFFFF5);

        // Three frames back to back: third stalls until a bank is released.
        apply_reset();
        send_frame(32'd100, 12, 11);
        send_frame(32'd200, 12, 11);
        bus_valid_i = 1'b1;
        bus_revis_i = 32'd300;
        bus_imvis_i = 32'd0 - 32'd300;
        for (int i = 0; i < 5; i++) tick();
        check_eq("stall_ready", {63'd0, bus_ready_o}, 64'd0);
        bus_valid_i = 1'b0;
        check_eq("stall_avail", {63'd0, frm_avail_o}, 64'd1);
        check_eq("stall_bank", {63'd0, frm_bank_o}, 64'd0);
        rd_check("f0_a0", 4'd0, vis_word(32'd100));
        rd_check("f0_a11", 4'd11, vis_word(32'd111));
        release_bank();
        check_eq("f1b_avail", {63'd0, frm_avail_o}, 64'd1);
        check_eq("f1b_bank", {63'd0, frm_bank_o}, 64'd1);
        check_eq("unstall_ready", {63'd0, bus_ready_o}, 64'd1);
        rd_check("f1b_a6", 4'd6, vis_word(32'd206));
        send_frame(32'd300, 12, 11);
        check_eq("f2_still_bank1", {63'd0, frm_bank_o}, 64'd1);
        release_bank();
        check_eq("f2_avail", {63'd0, frm_avail_o}, 64'd1);
        check_eq("f2_bank", {63'd0, frm_bank_o}, 64'd0);
        rd_check("f2_a4", 4'd4, vis_word(32'd304));
        rd_en_i    = 1'b1;
        rd_addr_i  = 4'd9;
        frm_done_i = 1'b1;
        tick();
        rd_en_i    = 1'b0;
        frm_done_i = 1'b0;
        check_eq("rddone_rdv", {63'd0, rd_valid_o}, 64'd1);
        check_eq("rddone_data", rd_data_o, vis_word(32'd309));
        check_eq("rddone_avail", {63'd0, frm_avail_o}, 64'd0);
        check_eq("rddone_bank", {63'd0, frm_bank_o}, 64'd1);

        // Early last on the 7th beat, then a good frame.
        apply_reset();
        send_frame(32'd50, 7, 6);
        check_eq("early_err", {63'd0, frm_err_o}, 64'd1);
        check_eq("early_cnt", {56'd0, err_count_o}, 64'd1);
        check_eq("early_avail", {63'd0, frm_avail_o}, 64'd0);
        tick();
        check_eq("early_err_end", {63'd0, frm_err_o}, 64'd0);
        send_frame(32'd400, 12, 11);
        check_eq("good_avail", {63'd0, frm_avail_o}, 64'd1);
        check_eq("good_bank", {63'd0, frm_bank_o}, 64'd0);
        rd_check("good_a0", 4'd0, vis_word(32'd400));
        rd_check("good_a6", 4'd6, vis_word(32'd406));
        rd_check("good_a11", 4'd11, vis_word(32'd411));

        // Overlong frame: 15 beats, error on the 12th.
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            send_beat(32'd500 + k, k == 14);
            check_eq($sformatf("long_err_b%0d", k), {63'd0, frm_err_o}, {63'd0, k == 11});
        end
        check_eq("long_cnt", {56'd0, err_count_o}, 64'd1);
        check_eq("long_avail", {63'd0, frm_avail_o}, 64'd0);

        // Error counter saturation.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame(32'd0, 2, 1);
            if (i == 253) check_eq("sat_254", {56'd0, err_count_o}, 64'd254);
            if (i == 254) check_eq("sat_255", {56'd0, err_count_o}, 64'd255);
        end
        check_eq("sat_300", {56'd0, err_count_o}, 64'd255);
        check_eq("sat_err_pulse", {63'd0, frm_err_o}, 64'd1);

        // Reset mid-frame with bank 1 full.
        apply_reset();
        send_frame(32'd600, 12, 11);
        send_frame(32'd700, 12, 11);
        release_bank();
        tick();
        for (int k = 0; k < 5; k++) send_beat(32'd800 + k, 1'b0);
        rd_check("pre_rst_a3", 4'd3, vis_word(32'd703));
        bus_reset = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick();
        bus_reset = 1'b0;
        send_frame(32'd900, 12, 11);
        check_eq("post_rst_avail", {63'd0, frm_avail_o}, 64'd1);
        check_eq("post_rst_bank", {63'd0, frm_bank_o}, 64'd0);
        rd_check("post_rst_a2", 4'd2, vis_word(32'd902));
        release_bank();
        check_eq("post_rst_empty", {63'd0, frm_avail_o}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
